// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller; MULDIV_STALL_EN enables multi-cycle DIV/REM occupancy of EX
// Mealy control outputs from STATE plus current inputs; saturating count of PC_WRITE=0 cycles.
module hazard_ctrl #(
   parameter int MD_LATENCY = 32
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        BUSYWAIT,
   input  logic [4:0]  ID_RS1,
   input  logic [4:0]  ID_RS2,
   input  logic        ID_USE_RS1,
   input  logic        ID_USE_RS2,
   input  logic [4:0]  EX_RD,
   input  logic        EX_MEMREAD,
   input  logic        EX_TAKEN,
   input  logic        EX_MD_START,
   output logic        PC_WRITE,
   output logic        IFID_HOLD,
   output logic        IDEX_HOLD,
   output logic        IFID_FLUSH,
   output logic        IDEX_FLUSH,
   output logic        EXMEM_FLUSH,
   output logic [1:0]  STATE,
   output logic [31:0] STALL_CYCLES
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_MD_BUSY  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] stall_q, stall_d;
   logic        load_use;

   assign load_use = EX_MEMREAD && (EX_RD != 5'd0) &&
                     ((ID_USE_RS1 && (ID_RS1 == EX_RD)) || (ID_USE_RS2 && (ID_RS2 == EX_RD)));

`ifdef MULDIV_STALL_EN
   // The first DIV cycle is spent in RUN, so the countdown covers the remaining stall cycles.
   localparam logic [5:0] MD_RELOAD = 6'(MD_LATENCY - 2);
   logic [5:0] md_cnt_q, md_cnt_d;
   logic       md_start;
   assign md_start = EX_MD_START && (MD_LATENCY > 1);
`else
   logic unused_md;
   assign unused_md = ^{EX_MD_START, 1'(MD_LATENCY)};
`endif

   always_comb begin
      PC_WRITE    = 1'b1;
      IFID_HOLD   = 1'b0;
      IDEX_HOLD   = 1'b0;
      IFID_FLUSH  = 1'b0;
      IDEX_FLUSH  = 1'b0;
      EXMEM_FLUSH = 1'b0;
      state_d     = ST_RUN;
`ifdef MULDIV_STALL_EN
      md_cnt_d    = md_cnt_q;
`endif
      if (RESET) begin
         PC_WRITE    = 1'b0;
         IFID_FLUSH  = 1'b1;
         IDEX_FLUSH  = 1'b1;
         EXMEM_FLUSH = 1'b1;
      end
`ifdef MULDIV_STALL_EN
      else if (state_q == ST_MD_BUSY) begin
         if (BUSYWAIT) begin
            PC_WRITE  = 1'b0;
            IFID_HOLD = 1'b1;
            IDEX_HOLD = 1'b1;
            state_d   = ST_MD_BUSY;
         end else if (md_cnt_q != 6'd0) begin
            PC_WRITE    = 1'b0;
            IFID_HOLD   = 1'b1;
            IDEX_HOLD   = 1'b1;
            EXMEM_FLUSH = 1'b1;
            md_cnt_d    = md_cnt_q - 6'd1;
            state_d     = ST_MD_BUSY;
         end
      end
`endif
      else if (BUSYWAIT) begin
         PC_WRITE  = 1'b0;
         IFID_HOLD = 1'b1;
         IDEX_HOLD = 1'b1;
         state_d   = ST_MEM_WAIT;
      end else if (EX_TAKEN) begin
         IFID_FLUSH = 1'b1;
         IDEX_FLUSH = 1'b1;
      end
`ifdef MULDIV_STALL_EN
      else if (md_start) begin
         PC_WRITE    = 1'b0;
         IFID_HOLD   = 1'b1;
         IDEX_HOLD   = 1'b1;
         EXMEM_FLUSH = 1'b1;
         md_cnt_d    = MD_RELOAD;
         state_d     = ST_MD_BUSY;
      end
`endif
      else if (load_use) begin
         PC_WRITE   = 1'b0;
         IFID_HOLD  = 1'b1;
         IDEX_FLUSH = 1'b1;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (!PC_WRITE && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_RUN;
         stall_q <= 32'd0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

`ifdef MULDIV_STALL_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         md_cnt_q <= 6'd0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end
`endif

   assign STATE        = state_q;
   assign STALL_CYCLES = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and random stimulus for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

   localparam int MD_LAT = 4;
`ifdef MULDIV_STALL_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET, BUSYWAIT, ID_USE_RS1, ID_USE_RS2, EX_MEMREAD, EX_TAKEN, EX_MD_START;
   logic [4:0]  ID_RS1, ID_RS2, EX_RD;
   logic        PC_WRITE, IFID_HOLD, IDEX_HOLD, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH;
   logic [1:0]  STATE;
   logic [31:0] STALL_CYCLES;

   hazard_ctrl #(.MD_LATENCY(MD_LAT)) dut (
      .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
      .EX_RD(EX_RD), .EX_MEMREAD(EX_MEMREAD), .EX_TAKEN(EX_TAKEN), .EX_MD_START(EX_MD_START),
      .PC_WRITE(PC_WRITE), .IFID_HOLD(IFID_HOLD), .IDEX_HOLD(IDEX_HOLD),
      .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH), .EXMEM_FLUSH(EXMEM_FLUSH),
      .STATE(STATE), .STALL_CYCLES(STALL_CYCLES)
   );

   always #5 CLK = ~CLK;

   int n_total = 0;
   int n_pass  = 0;

   // Model: memory-wait flag, DIV occupancy tracked as non-frozen cycles spent in EX.
   bit          m_valid = 1'b0;
   bit          m_mem_wait, m_div;
   int          m_div_seen;
   logic [31:0] m_stall;
   bit          n_mem_wait, n_div;
   int          n_div_seen;
   logic [31:0] n_stall;
   logic [5:0]  e_ctl;
   logic [5:0]  o_ctl;

   task automatic model_eval();
      bit lu;
      bit pc, ih, dh, ifl, dfl, efl;
      lu = EX_MEMREAD && (EX_RD != 0) &&
           ((ID_USE_RS1 && ID_RS1 == EX_RD) || (ID_USE_RS2 && ID_RS2 == EX_RD));
      pc = 1; ih = 0; dh = 0; ifl = 0; dfl = 0; efl = 0;
      n_mem_wait = 0; n_div = m_div; n_div_seen = m_div_seen;
      if (RESET) begin
         pc = 0; ifl = 1; dfl = 1; efl = 1;
         n_div = 0; n_div_seen = 0;
      end else if (m_div) begin
         if (BUSYWAIT) begin
            pc = 0; ih = 1; dh = 1;
         end else if (m_div_seen + 1 == MD_LAT) begin
            n_div = 0;
         end else begin
            pc = 0; ih = 1; dh = 1; efl = 1;
            n_div_seen = m_div_seen + 1;
         end
      end else if (BUSYWAIT) begin
         pc = 0; ih = 1; dh = 1; n_mem_wait = 1;
      end else if (EX_TAKEN) begin
         ifl = 1; dfl = 1;
      end else if (MD_EN && EX_MD_START && MD_LAT > 1) begin
         pc = 0; ih = 1; dh = 1; efl = 1;
         n_div = 1; n_div_seen = 1;
      end else if (lu) begin
         pc = 0; ih = 1; dfl = 1;
      end
      e_ctl = {pc, ih, dh, ifl, dfl, efl};
      if (RESET) n_stall = 0;
      else if (!pc && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
      else n_stall = m_stall;
   endtask

   task automatic step(input string tag);
      logic [1:0] e_state;
      #2;
      model_eval();
      o_ctl = {PC_WRITE, IFID_HOLD, IDEX_HOLD, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH};
      n_total++;
      assert (o_ctl === e_ctl) n_pass++;
      else $error("FAIL %s ctl {pc,ih,dh,if,df,ef} observed=%b expected=%b", tag, o_ctl, e_ctl);
      if (m_valid) begin
         e_state = m_mem_wait ? 2'd1 : (m_div ? 2'd2 : 2'd0);
         n_total++;
         assert (STATE === e_state) n_pass++;
         else $error("FAIL %s state observed=%0d expected=%0d", tag, STATE, e_state);
         n_total++;
         assert (STALL_CYCLES === m_stall) n_pass++;
         else $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, STALL_CYCLES, m_stall);
      end
      @(posedge CLK);
      if (RESET) m_valid = 1'b1;
      m_mem_wait = n_mem_wait; m_div = n_div; m_div_seen = n_div_seen; m_stall = n_stall;
      @(negedge CLK);
   endtask

   task automatic drive(input bit rst, input bit bw, input bit tk, input bit md, input bit mr,
                        input logic [4:0] rd, input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2, input string tag);
      RESET = rst; BUSYWAIT = bw; EX_TAKEN = tk; EX_MD_START = md; EX_MEMREAD = mr;
      EX_RD = rd; ID_RS1 = rs1; ID_USE_RS1 = u1; ID_RS2 = rs2; ID_USE_RS2 = u2;
      step(tag);
   endtask

   task automatic idle(input string tag);
      drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, tag);
   endtask

   initial begin
      m_mem_wait = 0; m_div = 0; m_div_seen = 0; m_stall = 0;
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, "reset0");
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, "reset1");
      idle("after_reset");
      // load-use on RS2, then defaults
      drive(0, 0, 0, 0, 1, 5'd5, 5'd1, 1, 5'd5, 1, "loaduse");
      idle("loaduse_release");
      drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, "load_x0");
      drive(0, 0, 0, 0, 1, 5'd5, 5'd1, 1, 5'd5, 0, "load_rs2_unused");
      drive(0, 0, 0, 0, 1, 5'd7, 5'd7, 1, 5'd2, 0, "loaduse_rs1");
      drive(0, 0, 1, 0, 1, 5'd5, 5'd5, 1, 5'd5, 1, "taken_and_loaduse");
      // busywait freeze, branch honoured on exit
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, "bw1");
      drive(0, 1, 1, 0, 1, 5'd3, 5'd3, 1, 5'd0, 0, "bw2");
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, "bw3");
      drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, "bw_exit_taken");
      // DIV pulse, with a 2-cycle busywait mid-stall
      drive(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, "md_start");
      idle("md_1");
      drive(0, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, "md_bw1");
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, "md_bw2");
      idle("md_2");
      drive(0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, "md_release_ignores");
      idle("md_after");
      // reset during DIV occupancy
      drive(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, "md_start2");
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, "md_reset");
      idle("post_reset");
      drive(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, "md_restart");
      for (int i = 0; i < 4; i++) idle("md_restart_run");
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
               5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), "random");
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
